// File: rtl/axis_pkt_scheduler.sv
// Round-robin packet scheduler: grants one AXI-Stream FIFO write port to N_SRC sources per packet.
// Optional per-source packet counters are compiled in with `define AXIS_PKT_SCHED_STATS_EN.
module axis_pkt_scheduler #(
    parameter int N_SRC        = 2,
    parameter int DW           = 64,
    parameter int PKT_SIZE_RST = 256
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic [31:0]           sys_addr_i,
    input  logic [31:0]           sys_wdata_i,
    input  logic [3:0]            sys_sel_i,
    input  logic                  sys_wen_i,
    input  logic                  sys_ren_i,
    output logic [31:0]           sys_rdata_o,
    output logic                  sys_err_o,
    output logic                  sys_ack_o,
    input  logic [N_SRC*DW-1:0]   src_tdata_i,
    input  logic [N_SRC-1:0]      src_tvalid_i,
    output logic [N_SRC-1:0]      src_tready_o,
    output logic [DW-1:0]         m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tlast_o,
    output logic [DW/8-1:0]       m_axis_tkeep_o
);

    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     next_grant;
    logic [GW-1:0]     cand;
    logic [31:0]       word_cnt;
    logic [31:0]       pkt_len;
    logic [31:0]       pkt_size;
    logic              ctrl_en;
    logic [N_SRC-1:0]  src_mask;
    logic [N_SRC-1:0]  req;
    logic [19:0]       addr;
    logic [31:0]       rd_val;
    logic              busy;
    logic              is_last;
    logic              hs;
    logic [DW-1:0]     src_data [N_SRC];
    logic              unused_ok;
    int                idx;

    assign unused_ok = ^{sys_sel_i, sys_addr_i[31:20]};

    assign addr = sys_addr_i[19:0];
    assign req  = src_tvalid_i & src_mask & {N_SRC{ctrl_en}};

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_data[g] = src_tdata_i[g*DW +: DW];
    end

    // Search downward so the candidate closest after last_grant is assigned last and wins.
    always_comb begin
        next_grant = last_grant;
        idx        = 0;
        cand       = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            cand = GW'(idx);
            if (req[cand]) begin
                next_grant = cand;
            end
        end
    end

    assign busy            = (state == XFER);
    assign is_last         = (word_cnt == pkt_len - 32'd1);
    assign m_axis_tvalid_o = busy & src_tvalid_i[grant];
    assign m_axis_tdata_o  = busy ? src_data[grant] : '0;
    assign m_axis_tlast_o  = m_axis_tvalid_o & is_last;
    assign m_axis_tkeep_o  = '1;
    assign hs              = m_axis_tvalid_o & m_axis_tready_i;
    assign sys_err_o       = 1'b0;

    always_comb begin
        src_tready_o = '0;
        if (busy) begin
            src_tready_o[grant] = m_axis_tready_i;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N_SRC - 1);
            word_cnt   <= '0;
            pkt_len    <= 32'(PKT_SIZE_RST);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= next_grant;
                        pkt_len  <= pkt_size;
                        word_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (hs) begin
                        word_cnt <= word_cnt + 32'd1;
                        if (is_last) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_PKT_SCHED_STATS_EN
    logic [31:0] pkt_cnt [N_SRC];

    // A clear write takes priority over a packet completing in the same cycle.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            for (int i = 0; i < N_SRC; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (sys_wen_i && addr == 20'h40) begin
            for (int i = 0; i < N_SRC; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (hs && is_last) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_val = 32'hFFFF_FFFF;
        case (addr)
            20'h00:  rd_val = {31'b0, ctrl_en};
            20'h04:  rd_val = 32'(src_mask);
            20'h08:  rd_val = pkt_size;
            20'h0C:  rd_val = {word_cnt[15:0], 12'b0, 3'(grant), busy};
            default: rd_val = 32'hFFFF_FFFF;
        endcase
`ifdef AXIS_PKT_SCHED_STATS_EN
        for (int i = 0; i < N_SRC; i++) begin
            if (addr == 20'(16 + 4 * i)) begin
                rd_val = pkt_cnt[i];
            end
        end
`endif
    end

    // Packet lengths below 2 are promoted to 2 so tlast never lands on the first word.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            sys_ack_o   <= 1'b0;
            sys_rdata_o <= '0;
            ctrl_en     <= 1'b0;
            src_mask    <= '1;
            pkt_size    <= 32'(PKT_SIZE_RST);
        end else begin
            sys_ack_o <= sys_wen_i | sys_ren_i;
            if (sys_ren_i) begin
                sys_rdata_o <= rd_val;
            end
            if (sys_wen_i) begin
                case (addr)
                    20'h00:  ctrl_en  <= sys_wdata_i[0];
                    20'h04:  src_mask <= sys_wdata_i[N_SRC-1:0];
                    20'h08:  pkt_size <= (sys_wdata_i < 32'd2) ? 32'd2 : sys_wdata_i;
                    default: ;
                endcase
            end
        end
    end

endmodule
